// File: rtl/reg_check_pkg.sv
// Shared encodings for the register check monitor: entry kinds, FSM states,
// and CPU register file geometry.
package reg_check_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  typedef enum logic {
    KIND_WAIT  = 1'b0,
    KIND_CHECK = 1'b1
  } entry_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the CPU integer register file: one write port fed by the
// writeback bus, one asynchronous read port. Register 0 is hardwired to zero.
module shadow_regfile
  import reg_check_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/reg_check_monitor.sv
// Walks a table of WAIT/CHECK entries against the shadow register file and
// reports PASS, a CHECK mismatch, or a timeout.
module reg_check_monitor
  import reg_check_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_we,
  input  logic [REG_AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic                       cfg_kind,
  input  logic [REG_AW-1:0]          cfg_reg,
  input  logic [XLEN-1:0]            cfg_value,
  input  logic [$clog2(DEPTH):0]     num_entries,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail_timeout,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [XLEN-1:0]            fail_got,
  output logic [XLEN-1:0]            fail_expected,
  output logic [$clog2(DEPTH):0]     checks_passed
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  entry_kind_e       kind_q [DEPTH];
  logic [REG_AW-1:0] reg_q  [DEPTH];
  logic [XLEN-1:0]   val_q  [DEPTH];
  logic [PW-1:0]     ptr_q, num_q;
  logic [TW-1:0]     tmr_q;

  logic              cfg_ok;
  logic [AW-1:0]     cur_idx;
  logic [XLEN-1:0]   shadow_val;
  logic              in_range, match, adv, mismatch, complete, tmo;

  assign cfg_ok = cfg_we && (state_q != ST_RUN);

  // Entry kinds come out of reset as WAIT; register/value fields are plain data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) kind_q[i] <= KIND_WAIT;
    end else if (cfg_ok) begin
      kind_q[cfg_idx] <= entry_kind_e'(cfg_kind);
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      reg_q[cfg_idx] <= cfg_reg;
      val_q[cfg_idx] <= cfg_value;
    end
  end

  assign cur_idx = ptr_q[AW-1:0];

  shadow_regfile #(.XLEN(XLEN)) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_we),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr (reg_q[cur_idx]),
    .rdata (shadow_val)
  );

  assign in_range = ptr_q < num_q;
  assign match    = shadow_val == val_q[cur_idx];
  assign adv      = in_range && match;
  assign mismatch = in_range && (kind_q[cur_idx] == KIND_CHECK) && !match;
  assign complete = !in_range || (adv && ((ptr_q + PW'(1)) == num_q));
  assign tmo      = tmr_q == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Mismatch beats completion, completion beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mismatch)      state_d = ST_FAIL;
        else if (complete) state_d = ST_PASS;
        else if (tmo)      state_d = ST_FAIL;
      end
      default: if (start) state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q         <= '0;
      ptr_q         <= '0;
      tmr_q         <= '0;
      checks_passed <= '0;
      fail_timeout  <= 1'b0;
      fail_idx      <= '0;
      fail_got      <= '0;
      fail_expected <= '0;
    end else if (state_q != ST_RUN) begin
      if (start) begin
        num_q         <= num_entries;
        ptr_q         <= '0;
        tmr_q         <= '0;
        checks_passed <= '0;
        fail_timeout  <= 1'b0;
        fail_idx      <= '0;
        fail_got      <= '0;
        fail_expected <= '0;
      end
    end else begin
      tmr_q <= tmr_q + TW'(1);
      if (mismatch) begin
        fail_timeout  <= 1'b0;
        fail_idx      <= cur_idx;
        fail_got      <= shadow_val;
        fail_expected <= val_q[cur_idx];
      end else begin
        if (adv) ptr_q <= ptr_q + PW'(1);
        if (adv && (kind_q[cur_idx] == KIND_CHECK)) checks_passed <= checks_passed + PW'(1);
        if (!complete && tmo) begin
          fail_timeout  <= 1'b1;
          fail_idx      <= cur_idx;
          fail_got      <= shadow_val;
          fail_expected <= val_q[cur_idx];
        end
      end
    end
  end

  assign busy = state_q == ST_RUN;
  assign done = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass = state_q == ST_PASS;

endmodule

// File: tb/tb_reg_check_monitor.sv
// Directed bench for reg_check_monitor: expected run outcomes are queued at
// start and compared when done rises.
module tb_reg_check_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic        cfg_kind;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_value;
  logic [3:0]  num_entries;
  logic        start;
  logic        busy, done, pass, fail_timeout;
  logic [2:0]  fail_idx;
  logic [31:0] fail_got, fail_expected;
  logic [3:0]  checks_passed;

  reg_check_monitor #(.XLEN(32), .DEPTH(8), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_kind(cfg_kind), .cfg_reg(cfg_reg),
    .cfg_value(cfg_value), .num_entries(num_entries), .start(start),
    .busy(busy), .done(done), .pass(pass), .fail_timeout(fail_timeout),
    .fail_idx(fail_idx), .fail_got(fail_got), .fail_expected(fail_expected),
    .checks_passed(checks_passed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [2:0]  idx;
    logic [31:0] got;
    logic [31:0] exp;
    logic [3:0]  cp;
    logic        chk_got;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_cnt = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic exp_t mk(input logic p, input logic t, input logic [2:0] i,
                              input logic [31:0] g, input logic [31:0] e,
                              input logic [3:0] c, input logic cg, input int l);
    exp_t r;
    r.pass = p; r.tmo = t; r.idx = i; r.got = g; r.exp = e;
    r.cp = c; r.chk_got = cg; r.lat = l;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int idx, input logic kind, input int r, input int v);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_kind = kind; cfg_reg = 5'(r); cfg_value = 32'(v);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wb(input int r, input int v, input int gap);
    wb_we = 1'b1; wb_addr = 5'(r); wb_data = 32'(v);
    @(negedge clk);
    wb_we = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic start_run(input int n, input exp_t e);
    sb.push_back(e);
    num_entries = 4'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc_cnt;
  endtask

  task automatic wait_and_score(input string tag, input int budget);
    exp_t e;
    int   n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check({tag, "_pass"}, pass, e.pass);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_tmo"}, fail_timeout, e.tmo);
      check({tag, "_cp"}, checks_passed, e.cp);
      check({tag, "_idx"}, fail_idx, e.idx);
      check({tag, "_fexp"}, fail_expected, e.exp);
      if (e.chk_got) check({tag, "_fgot"}, fail_got, e.got);
      if (e.lat >= 0) check({tag, "_lat"}, cyc_cnt - start_cyc, e.lat);
    end
  endtask

  initial begin
    rst = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_kind = 1'b0; cfg_reg = '0; cfg_value = '0;
    num_entries = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_tmo", fail_timeout, 1'b0);
    check("rst_idx", fail_idx, 3'd0);
    check("rst_got", fail_got, 32'd0);
    check("rst_fexp", fail_expected, 32'd0);
    check("rst_cp", checks_passed, 4'd0);
    rst = 1'b0;
    @(negedge clk);

    // Writeback sequence that satisfies every entry.
    cfg(0, 1'b0, 20, 1);
    cfg(1, 1'b1, 1, 300);
    cfg(2, 1'b0, 20, 2);
    cfg(3, 1'b1, 1, 500);
    cfg(4, 1'b1, 2, 100);
    start_run(5, mk(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd3, 1'b0, -1));
    check("seq_busy", busy, 1'b1);
    wb(1, 300, 3); wb(20, 1, 3); wb(1, 500, 3); wb(2, 100, 3); wb(20, 2, 0);
    wait_and_score("seq_pass", 50);

    // Same table, last CHECK sees a wrong value.
    start_run(5, mk(1'b0, 1'b0, 3'd4, 32'd99, 32'd100, 4'd2, 1'b1, -1));
    wb(1, 300, 3); wb(20, 1, 3); wb(1, 500, 3); wb(2, 99, 3); wb(20, 2, 0);
    wait_and_score("seq_fail", 50);
    repeat (5) @(negedge clk);
    check("fail_hold_pass", pass, 1'b0);
    check("fail_hold_idx", fail_idx, 3'd4);

    // Timeout with the awaited register never written.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    cfg(0, 1'b0, 20, 1);
    start_run(1, mk(1'b0, 1'b1, 3'd0, 32'd0, 32'd1, 4'd0, 1'b0, 1000));
    repeat (500) @(negedge clk);
    check("tmo_midrun_busy", busy, 1'b1);
    wait_and_score("timeout", 700);

    // Empty table, then CHECK x0==0 after a write to x0.
    start_run(0, mk(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1));
    wait_and_score("empty", 10);
    cfg(0, 1'b1, 0, 0);
    wb(0, 5, 1);
    start_run(1, mk(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd1, 1'b0, -1));
    wait_and_score("x0_zero", 10);

    // start and cfg_we during RUN must be ignored.
    cfg(0, 1'b0, 3, 7);
    cfg(1, 1'b1, 4, 9);
    start_run(2, mk(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd1, 1'b0, -1));
    repeat (2) @(negedge clk);
    cfg(1, 1'b0, 4, 123);
    num_entries = 4'd0; start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("ign_busy", busy, 1'b1);
    wb(4, 9, 1); wb(3, 7, 0);
    wait_and_score("ign_run", 20);
    start_run(2, mk(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd1, 1'b0, -1));
    wait_and_score("ign_readback", 20);

    // Asynchronous reset mid-run, then a clean rerun.
    cfg(0, 1'b0, 5, 11);
    start_run(1, mk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, -1));
    repeat (3) @(negedge clk);
    check("abort_busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    void'(sb.pop_back());
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    check("abort_start_ign", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 1'b0);
    cfg(0, 1'b0, 5, 11);
    start_run(1, mk(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, -1));
    wb(5, 11, 0);
    wait_and_score("rerun", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
